pe_pipelined_mac: RTL

Parametrised, pipelined successor to the single-cycle processing element, used as the arithmetic tile in the NPU compute array. Adds configurable data width, a two-stage pipeline with valid/ready back-pressure, and accumulator clear/read opcodes. Saturating arithmetic is a compile-time option. Sits between the operand scheduler (upstream) and the result collector (downstream).

---
 rtl/pe_pipelined_mac.sv | 123 ++++++++++++
 1 files changed

// File: rtl/pe_pipelined_mac.sv
// pe_pipelined_mac: two-stage pipelined ALU/MAC tile with global-stall valid/ready flow control.
// Define PE_SATURATE_EN for signed saturating ADD/SUB/MUL/MAC; otherwise results wrap.
module pe_pipelined_mac #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    input  logic [3:0]            operation,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  err_op
);
    localparam int W = DATA_WIDTH;
`ifdef PE_SATURATE_EN
    localparam int PW = 2 * W;
`else
    localparam int PW = W;
`endif
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_MUL = 4'd3;
    localparam logic [3:0] OP_MAC = 4'd4;
    localparam logic [3:0] OP_CLR = 4'd5;
    localparam logic [3:0] OP_RD  = 4'd6;

    logic          s1_valid_q, s1_valid_d;
    logic [3:0]    s1_op_q, s1_op_d;
    logic [W-1:0]  s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [PW-1:0] s1_prod_q, s1_prod_d;
    logic [W-1:0]  acc_q, acc_d, result_q, result_d;
    logic          out_valid_q, out_valid_d, err_q, err_d;
    logic          stall, op_ok;
    logic [PW-1:0] ax, bx;
    logic [W-1:0]  add_r, sub_r, mul_r, mac_r, res;

    assign stall    = out_valid_q && !out_ready;
    assign in_ready = rst_n && !stall;
    assign ax       = PW'($signed(op_a));
    assign bx       = PW'($signed(op_b));
    assign op_ok    = s1_op_q >= OP_ADD && s1_op_q <= OP_RD;

`ifdef PE_SATURATE_EN
    // Clamp a (2W+1)-bit signed value into the W-bit signed range.
    function automatic logic [W-1:0] sat(input logic [2*W:0] v);
        return (&v[2*W:W-1] || ~|v[2*W:W-1]) ? v[W-1:0] : {v[2*W], {(W-1){~v[2*W]}}};
    endfunction
    function automatic logic [2*W:0] sx(input logic [W-1:0] v);
        return (2*W+1)'($signed(v));
    endfunction
    assign add_r = sat(sx(s1_a_q) + sx(s1_b_q));
    assign sub_r = sat(sx(s1_a_q) - sx(s1_b_q));
    assign mul_r = sat({s1_prod_q[PW-1], s1_prod_q});
    assign mac_r = sat(sx(acc_q) + sx(mul_r));
`else
    assign add_r = s1_a_q + s1_b_q;
    assign sub_r = s1_a_q - s1_b_q;
    assign mul_r = s1_prod_q;
    assign mac_r = acc_q + mul_r;
`endif

    assign res = s1_op_q == OP_ADD ? add_r :
                 s1_op_q == OP_SUB ? sub_r :
                 s1_op_q == OP_MUL ? mul_r :
                 s1_op_q == OP_MAC ? mac_r :
                 s1_op_q == OP_RD  ? acc_q : '0;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_op_d     = s1_op_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_prod_d   = s1_prod_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        acc_d       = acc_q;
        err_d       = 1'b0;
        if (!stall) begin
            s1_valid_d  = in_valid;
            s1_op_d     = operation;
            s1_a_d      = op_a;
            s1_b_d      = op_b;
            s1_prod_d   = ax * bx;
            out_valid_d = s1_valid_q && op_ok;
            err_d       = s1_valid_q && !op_ok;
            result_d    = out_valid_d ? res : result_q;
            acc_d       = (s1_valid_q && s1_op_q == OP_MAC) ? mac_r :
                          (s1_valid_q && s1_op_q == OP_CLR) ? '0 : acc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= '0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_prod_q   <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            acc_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_prod_q   <= s1_prod_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            acc_q       <= acc_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign err_op    = err_q;
endmodule
